dual_pueo_thresh_sequencer: RTL and testbench
=============================================

// Module: dual_pueo_thresh_sequencer
// PURPOSE
//  Owns the threshold shadow RAM for a cascade of NPAIR dual_pueo beam pairs (A/B threshold each, 18 b).
//  On a load request it streams all stored thresholds into the cascade: the thresh bus plus per-half write strobes.
//  It then pulses the per-half update strobe so every pair commits its new thresholds in the same cycle.
//  Sits between the register/control interface and the first beam pair (thresh_i/thresh_wr_i/thresh_update_i).
// PARAMETERS
//  NPAIR      24  number of beam pairs in the cascade (2..64)
//  TBITS      18  threshold width per half
//  SETTLE      2  idle cycles between last cascade write and update pulse (0..15)
// PORTS
//  clk_i            in   1        single clock
//  rst_ni           in   1        asynchronous, active-low reset
//  wr_valid_i       in   1        shadow RAM write request
//  wr_ready_o       out  1        high when a write is accepted (state IDLE)
//  wr_addr_i        in   6        pair index, 0 = first pair in the cascade
//  wr_half_i        in   1        0 = A half [17:0], 1 = B half [35:18]
//  wr_data_i        in   TBITS    threshold value
//  load_req_i       in   2        load request mask, [0]=A [1]=B; a single-cycle pulse is sufficient
//  busy_o           out  1        sequence in progress
//  done_o           out  1        one-cycle pulse in the cycle after the update pulse
//  thresh_o         out  2*TBITS  {B,A} threshold to cascade head
//  thresh_wr_o      out  2        per-half cascade shift strobe
//  thresh_update_o  out  2        per-half commit strobe
// BEHAVIOUR
//  Reset: all outputs 0 except wr_ready_o=1; FSM=IDLE; pending mask cleared.
//   Shadow RAM contents are undefined after power-up and are NOT cleared by reset.
//  Write: accepted when wr_valid_i & wr_ready_o. wr_addr_i>=NPAIR is accepted and discarded.
//   wr_ready_o=0 in every state except IDLE.
//  FSM states: IDLE -> PREFETCH -> SHIFT -> SETTLE -> UPDATE -> IDLE.
//  IDLE: if load_req_i!=0 (or pending!=0), latch the mask as active, clear pending, go to PREFETCH.
//   A load request of 00 is ignored.
//  PREFETCH (1 cyc): issue RAM read of index NPAIR-1 (1-cycle read latency).
//  SHIFT (NPAIR cyc): on shift cycle k (k=0..NPAIR-1):
//   - thresh_o = RAM[NPAIR-1-k], both halves driven regardless of mask;
//   - thresh_wr_o = active mask;
//   - the next index is prefetched.
//   Last index first, so that after NPAIR shifts pair j holds RAM[j].
//  SETTLE: SETTLE cycles with thresh_wr_o=0; skipped when SETTLE=0.
//  UPDATE (1 cyc): thresh_update_o = active mask; thresh_wr_o=0.
//   Next cycle: done_o=1, FSM=IDLE, busy_o=0 (busy_o=0 only in IDLE).
//  Latency: req at cycle t -> first thresh_wr at t+2 -> last at t+NPAIR+1
//   -> update at t+NPAIR+2+SETTLE -> done_o at t+NPAIR+3+SETTLE.
//  thresh_o holds its last value when not shifting.
//   thresh_wr_o and thresh_update_o are never both nonzero in the same cycle.
//  load_req_i while busy: OR'd into pending (a single pending slot, merged masks).
//   Pending is serviced from IDLE on the cycle after done_o.
//  load_req_i in the same cycle as the done_o cycle: treated as pending, with identical timing.
//  Write and load in the same IDLE cycle: the write commits first, so the load streams the new value.
//  Reset mid-sequence: outputs drop to 0 immediately.
//   No update pulse is issued; cascade contents are partial but uncommitted, so live thresholds are unchanged.
//  Index counter is 6 b and stops at 0; no wrap.
// TESTING
//  1. Reset, write RAM[j]=0x100+j (A) and 0x200+j (B) for NPAIR=24, load 11
//     -> 24 wr strobes carry 0x117/0x217 first and 0x100/0x200 last;
//     -> update=11 at t+28, done at t+29.
//  2. Load mask 01 -> thresh_wr_o and thresh_update_o only ever equal 01; bit1 stays 0 throughout.
//  3. load 01 then load 10 at t+5 (busy)
//     -> the first sequence completes, a second sequence with mask 10 starts at done+1;
//     -> a third request 01 issued during the first sequence merges, so the second sequence uses mask 11.
//  4. wr_valid_i held during SHIFT -> wr_ready_o=0 and RAM unchanged;
//     -> the write is accepted in the first IDLE cycle; wr_addr=40 accepted and ignored.
//  5. Assert rst_ni low at shift k=10 -> all strobes 0 asynchronously; no update pulse.
//     -> After release, load 11 replays the full sequence correctly.
//  6. SETTLE=0 build: update pulse directly follows the last write (t+NPAIR+2); checker: wr&update never overlap.

Source files
------------

// File: rtl/dual_pueo_thresh_sequencer.sv
// dual_pueo_thresh_sequencer
//   Holds the threshold shadow RAM for a cascade of NPAIR dual_pueo beam pairs
//   (A and B half, TBITS each). A load request streams every stored threshold
//   into the cascade, last pair first, then pulses the commit strobe so all
//   pairs adopt their new thresholds in the same cycle.
//
//   State table
//     state    | meaning
//     IDLE     | accepts RAM writes, waits for a load request or pending mask
//     PREFETCH | reads the last RAM entry (one-cycle read latency)
//     SHIFT    | drives one threshold per cycle onto the cascade, NPAIR cycles
//     SETTLE   | SETTLE quiet cycles before the commit (skipped if SETTLE=0)
//     UPDATE   | one-cycle commit strobe; done_o follows in the next cycle
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   wr_valid_i/wr_ready_o  shadow RAM write handshake (ready only in IDLE)
//   wr_addr_i, wr_half_i   pair index and half (0 = A, 1 = B) of the write
//   wr_data_i              threshold value
//   load_req_i             load mask, [0]=A [1]=B
//   busy_o, done_o         sequence in progress / one-cycle completion pulse
//   thresh_o               {B,A} threshold to the cascade head
//   thresh_wr_o            per-half cascade shift strobe
//   thresh_update_o        per-half commit strobe
module dual_pueo_thresh_sequencer #(
    parameter int NPAIR  = 24,
    parameter int TBITS  = 18,
    parameter int SETTLE = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [5:0]           wr_addr_i,
    input  logic                 wr_half_i,
    input  logic [TBITS-1:0]     wr_data_i,
    input  logic [1:0]           load_req_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*TBITS-1:0]   thresh_o,
    output logic [1:0]           thresh_wr_o,
    output logic [1:0]           thresh_update_o
);

    localparam int               AW        = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [5:0]       LAST_IDX  = 6'(NPAIR - 1);
    localparam logic [AW-1:0]    LAST_RD   = AW'(NPAIR - 1);
    localparam logic [6:0]       NPAIR_W   = 7'(NPAIR);
    localparam logic [3:0]       SETTLE_LD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_SETTLE   = 3'd3;
    localparam logic [2:0] S_UPDATE   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [5:0]           idx_q, idx_d;
    logic [3:0]           settle_q, settle_d;
    logic [1:0]           active_q, active_d;
    logic [1:0]           pending_q, pending_d;
    logic [2*TBITS-1:0]   thresh_q, thresh_d;
    logic                 done_q, done_d;

    logic [TBITS-1:0]     ram_a_q [NPAIR];
    logic [TBITS-1:0]     ram_b_q [NPAIR];
    logic [AW-1:0]        rd_idx;
    logic [5:0]           idx_m1;
    logic                 wr_en;

    // Out-of-range addresses complete the handshake but never touch the RAM.
    assign wr_en = wr_valid_i && (state_q == S_IDLE) && ({1'b0, wr_addr_i} < NPAIR_W);

    // Shadow RAM is deliberately not reset: contents survive rst_ni so a
    // sequence aborted by reset can be replayed without rewriting.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            if (wr_half_i) begin
                ram_b_q[wr_addr_i[AW-1:0]] <= wr_data_i;
            end else begin
                ram_a_q[wr_addr_i[AW-1:0]] <= wr_data_i;
            end
        end
    end

    assign idx_m1 = idx_q - 6'd1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        active_d  = active_q;
        thresh_d  = thresh_q;
        done_d    = 1'b0;
        rd_idx    = LAST_RD;
        // Requests arriving while busy merge into a single pending slot.
        pending_d = (state_q == S_IDLE) ? 2'b00 : (pending_q | load_req_i);

        case (state_q)
            S_IDLE: begin
                if ((load_req_i | pending_q) != 2'b00) begin
                    active_d = load_req_i | pending_q;
                    state_d  = S_PREFETCH;
                end
            end
            S_PREFETCH: begin
                rd_idx   = LAST_RD;
                thresh_d = {ram_b_q[rd_idx], ram_a_q[rd_idx]};
                idx_d    = LAST_IDX;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                // idx_q names the entry on thresh_o this cycle; fetch the next
                // one for the following shift until entry 0 has gone out.
                if (idx_q == 6'd0) begin
                    settle_d = SETTLE_LD;
                    state_d  = (SETTLE == 0) ? S_UPDATE : S_SETTLE;
                end else begin
                    rd_idx   = idx_m1[AW-1:0];
                    thresh_d = {ram_b_q[rd_idx], ram_a_q[rd_idx]};
                    idx_d    = idx_m1;
                end
            end
            S_SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = S_UPDATE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_UPDATE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= 6'd0;
            settle_q  <= 4'd0;
            active_q  <= 2'b00;
            pending_q <= 2'b00;
            thresh_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            thresh_q  <= thresh_d;
            done_q    <= done_d;
        end
    end

    // Strobes decode directly from the state register so an asynchronous
    // reset silences them without waiting for a clock edge.
    assign thresh_wr_o     = (state_q == S_SHIFT)  ? active_q : 2'b00;
    assign thresh_update_o = (state_q == S_UPDATE) ? active_q : 2'b00;
    assign busy_o          = (state_q != S_IDLE);
    assign wr_ready_o      = (state_q == S_IDLE);
    assign done_o          = done_q;
    assign thresh_o        = thresh_q;

endmodule

// File: tb/tb_dual_pueo_thresh_sequencer.sv
// Testbench for dual_pueo_thresh_sequencer: a SETTLE=2 instance carries most
// scenarios, a SETTLE=0 instance (sharing the write port) covers the
// no-settle timing. Expected streams come from a shadow-RAM model plus the
// request-to-strobe latency rules.
module tb_dual_pueo_thresh_sequencer;
    localparam int NPAIR = 24;
    localparam int TBITS = 18;
    localparam int S     = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              wr_valid;
    logic [5:0]        wr_addr;
    logic              wr_half;
    logic [TBITS-1:0]  wr_data;
    logic [1:0]        ld, ld0;

    logic              rdy, busy, done, rdy0, busy0, done0;
    logic [2*TBITS-1:0] th, th0;
    logic [1:0]        twr, tup, twr0, tup0;

    dual_pueo_thresh_sequencer #(.NPAIR(NPAIR), .TBITS(TBITS), .SETTLE(S)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(rdy),
        .wr_addr_i(wr_addr), .wr_half_i(wr_half), .wr_data_i(wr_data),
        .load_req_i(ld), .busy_o(busy), .done_o(done), .thresh_o(th),
        .thresh_wr_o(twr), .thresh_update_o(tup));

    dual_pueo_thresh_sequencer #(.NPAIR(NPAIR), .TBITS(TBITS), .SETTLE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(rdy0),
        .wr_addr_i(wr_addr), .wr_half_i(wr_half), .wr_data_i(wr_data),
        .load_req_i(ld0), .busy_o(busy0), .done_o(done0), .thresh_o(th0),
        .thresh_wr_o(twr0), .thresh_update_o(tup0));

    int n_cmp = 0;
    int n_mis = 0;
    logic [TBITS-1:0] m_a [NPAIR];
    logic [TBITS-1:0] m_b [NPAIR];

    // Shift and commit strobes must never coincide on either instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_cmp++;
            if (((twr != 2'b00) && (tup != 2'b00)) || ((twr0 != 2'b00) && (tup0 != 2'b00))) begin
                n_mis++;
                $display("FAIL overlap: wr=%b/%b upd=%b/%b required no overlap", twr, twr0, tup, tup0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observes one sequence cycle by cycle. The request cycle is the negedge
    // just before the call; offset k is the k-th following cycle.
    task automatic watch_seq(input bit sel0, input logic [1:0] mask,
                             input int inj_k1, input logic [1:0] inj_m1,
                             input int inj_k2, input logic [1:0] inj_m2,
                             input int wr_k, input string tag);
        int sset = sel0 ? 0 : S;
        int len  = NPAIR + 3 + sset;
        logic [1:0] e_wr, e_up, o_wr, o_up;
        logic e_busy, e_done, o_busy, o_done, o_rdy;
        logic [2*TBITS-1:0] o_th, e_th;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            o_wr = sel0 ? twr0 : twr;   o_up = sel0 ? tup0 : tup;
            o_busy = sel0 ? busy0 : busy; o_done = sel0 ? done0 : done;
            o_rdy = sel0 ? rdy0 : rdy;  o_th = sel0 ? th0 : th;
            e_wr   = (k >= 2 && k <= NPAIR + 1) ? mask : 2'b00;
            e_up   = (k == NPAIR + 2 + sset) ? mask : 2'b00;
            e_done = (k == len);
            e_busy = (k < len);
            n_cmp++;
            if ({o_busy, o_done, o_rdy, o_wr, o_up} !== {e_busy, e_done, ~e_busy, e_wr, e_up}) begin
                n_mis++;
                $display("FAIL %s k=%0d: busy/done/rdy/wr/upd=%b%b%b/%b/%b required %b%b%b/%b/%b",
                         tag, k, o_busy, o_done, o_rdy, o_wr, o_up, e_busy, e_done, ~e_busy, e_wr, e_up);
            end
            if (e_wr != 2'b00) begin
                e_th = {m_b[NPAIR + 1 - k], m_a[NPAIR + 1 - k]};
                n_cmp++;
                if (o_th !== e_th) begin
                    n_mis++;
                    $display("FAIL %s_data k=%0d: thresh=%h required %h", tag, k, o_th, e_th);
                end
            end
            if (sel0) ld0 = (k == inj_k1) ? inj_m1 : (k == inj_k2) ? inj_m2 : 2'b00;
            else      ld  = (k == inj_k1) ? inj_m1 : (k == inj_k2) ? inj_m2 : 2'b00;
            if (k == wr_k) wr_valid = 1'b1;
            else if (wr_k < 0) wr_valid = 1'b0;
        end
    endtask

    task automatic write_ram(input logic [5:0] a, input logic h, input logic [TBITS-1:0] d);
        int waited = 0;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = a; wr_half = h; wr_data = d;
        while (!rdy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy) begin
            n_cmp++; n_mis++;
            $display("FAIL write_timeout: ready=%b required 1", rdy);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        if (a < NPAIR) begin
            if (h) m_b[a] = d; else m_a[a] = d;
        end
    endtask

    task automatic start_load(input bit sel0, input logic [1:0] mask);
        @(negedge clk);
        if (sel0) ld0 = mask; else ld = mask;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_half = 1'b0; wr_data = '0;
        ld = 2'b00; ld0 = 2'b00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rdy, busy, done, twr, tup, th} !== {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, {2*TBITS{1'b0}}}) begin
            n_mis++;
            $display("FAIL reset: rdy=%b busy=%b done=%b wr=%b upd=%b th=%h required 1 0 0 00 00 0",
                     rdy, busy, done, twr, tup, th);
        end
        rst_n = 1'b1;
        @(negedge clk);
        // A zero mask is not a request.
        ld = 2'b00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL zero_mask: busy=%b required 0", busy);
        end
    endtask

    task automatic test_full_load();
        for (int j = 0; j < NPAIR; j++) begin
            write_ram(6'(j), 1'b0, TBITS'(32'h100 + j));
            write_ram(6'(j), 1'b1, TBITS'(32'h200 + j));
        end
        start_load(1'b0, 2'b11);
        watch_seq(1'b0, 2'b11, -1, 2'b00, -1, 2'b00, -1, "full_load");
    endtask

    task automatic test_mask_a();
        start_load(1'b0, 2'b01);
        watch_seq(1'b0, 2'b01, -1, 2'b00, -1, 2'b00, -1, "mask_a");
    endtask

    task automatic test_pending();
        start_load(1'b0, 2'b01);
        watch_seq(1'b0, 2'b01, 5, 2'b10, -1, 2'b00, -1, "pend_first");
        watch_seq(1'b0, 2'b10, -1, 2'b00, -1, 2'b00, -1, "pend_second");
        start_load(1'b0, 2'b01);
        watch_seq(1'b0, 2'b01, 5, 2'b10, 12, 2'b01, -1, "merge_first");
        watch_seq(1'b0, 2'b11, -1, 2'b00, -1, 2'b00, -1, "merge_second");
        start_load(1'b0, 2'b01);
        watch_seq(1'b0, 2'b01, NPAIR + 3 + S, 2'b10, -1, 2'b00, -1, "done_cyc_first");
        watch_seq(1'b0, 2'b10, -1, 2'b00, -1, 2'b00, -1, "done_cyc_second");
    endtask

    task automatic test_write_blocked();
        logic [TBITS-1:0] nv = TBITS'($urandom);
        wr_addr = 6'd3; wr_half = 1'b1; wr_data = nv;
        start_load(1'b0, 2'b11);
        watch_seq(1'b0, 2'b11, -1, 2'b00, -1, 2'b00, 5, "wr_blocked");
        @(negedge clk);
        wr_valid = 1'b0;
        m_b[3] = nv;
        write_ram(6'd40, 1'b0, TBITS'($urandom));
        start_load(1'b0, 2'b11);
        watch_seq(1'b0, 2'b11, -1, 2'b00, -1, 2'b00, -1, "wr_after");
    endtask

    task automatic test_write_and_load();
        logic [TBITS-1:0] nv = TBITS'($urandom);
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 6'(NPAIR - 1); wr_half = 1'b0; wr_data = nv; ld = 2'b11;
        m_a[NPAIR - 1] = nv;
        watch_seq(1'b0, 2'b11, -1, 2'b00, -1, 2'b00, -1, "wr_and_load");
    endtask

    task automatic test_reset_mid();
        start_load(1'b0, 2'b11);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ld = 2'b00;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({twr, tup, busy, rdy, th} !== {2'b00, 2'b00, 1'b0, 1'b1, {2*TBITS{1'b0}}}) begin
            n_mis++;
            $display("FAIL reset_mid: wr=%b upd=%b busy=%b rdy=%b th=%h required 00 00 0 1 0",
                     twr, tup, busy, rdy, th);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (tup !== 2'b00 || twr !== 2'b00) begin
                n_mis++;
                $display("FAIL reset_hold: wr=%b upd=%b required 00", twr, tup);
            end
        end
        rst_n = 1'b1;
        start_load(1'b0, 2'b11);
        watch_seq(1'b0, 2'b11, -1, 2'b00, -1, 2'b00, -1, "replay");
    endtask

    task automatic test_random();
        logic [1:0] m;
        for (int it = 0; it < 4; it++) begin
            for (int w = 0; w < 6; w++) begin
                write_ram(6'($urandom_range(NPAIR - 1, 0)), 1'($urandom), TBITS'($urandom));
            end
            m = 2'($urandom_range(3, 1));
            start_load(1'b0, m);
            watch_seq(1'b0, m, -1, 2'b00, -1, 2'b00, -1, "random");
        end
    endtask

    task automatic test_settle0();
        start_load(1'b1, 2'b11);
        watch_seq(1'b1, 2'b11, -1, 2'b00, -1, 2'b00, -1, "settle0");
        start_load(1'b1, 2'b10);
        watch_seq(1'b1, 2'b10, -1, 2'b00, -1, 2'b00, -1, "settle0_b");
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_mask_a();
        test_pending();
        test_write_blocked();
        test_write_and_load();
        test_reset_mid();
        test_random();
        test_settle0();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
